// File: rtl/sample_writer.sv
// sample_writer: ADC-side producer for the ping-pong sample buffer.
// Captures 10-bit ADC words on writeClock and drives the buffer write port.
// Capture starts and stops on the synchronised collect request, and stops only
// on block boundaries. Buffer overflow is latched because the buffer clears its
// own flag once writing stops.
//
// Optional feature: define SAMPLE_WRITER_TEST_PATTERN_EN to build the 10-bit
// test-pattern counter, selected by testMode when capture starts.
//
// Ports:
//   writeClock      ADC sample clock
//   nReset          asynchronous, active-low reset
//   collectData     capture request (asynchronous, USB domain)
//   testMode        select test pattern (pattern build only)
//   adcData         raw ADC word, valid every writeClock
//   bufferOverflow  overflow flag from buffer (writeClock domain)
//   isWriting       buffer write request, one word per cycle while high
//   dataOut         word to buffer, qualified by isWriting
//   captureActive   high in DISCARD, CAPTURE and DRAIN
//   overflowLatched sticky overflow indicator, cleared on next start
//   blockCount      completed blocks since capture start (wraps)
module sample_writer #(
  parameter int unsigned DISCARD_SAMPLES = 16,
  parameter int unsigned BLOCK_WORDS     = 8192,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        writeClock,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        testMode,
  input  logic [9:0]  adcData,
  input  logic        bufferOverflow,
  output logic        isWriting,
  output logic [9:0]  dataOut,
  output logic        captureActive,
  output logic        overflowLatched,
  output logic [15:0] blockCount
);

  localparam int unsigned DATA_W = 10;
  localparam int unsigned WC_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned DC_W   = $clog2(DISCARD_SAMPLES + 1);
  localparam int unsigned BC_W   = 16;

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BLOCK_WORDS - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DISCARD_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DISCARD = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [DC_W-1:0]         discard_cnt_q;
  logic [WC_W-1:0]         word_count_q;
  logic [BC_W-1:0]         block_count_q;
  logic                    is_writing_q;
  logic                    capture_active_q;
  logic                    overflow_q;
  logic [DATA_W-1:0]       data_out_q;

  logic collect_sync;
  logic start;
  logic block_done;

  assign collect_sync = sync_q[SYNC_STAGES-1];
  assign start        = (state_q == IDLE) && collect_sync;
  // The word presented this cycle is the last of its block and is written at this edge.
  assign block_done   = is_writing_q && (word_count_q == WC_LAST);

  // Collect request synchroniser
  always_ff @(posedge writeClock or negedge nReset) begin
    if (!nReset) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], collectData};
  end

  // Capture FSM with registered write request, status and word/block counters.
  // isWriting follows the state register, so a stop decision taken at the edge
  // that writes the last word of a block leaves no stray word in the buffer.
  always_ff @(posedge writeClock or negedge nReset) begin
    if (!nReset) begin
      state_q          <= IDLE;
      discard_cnt_q    <= '0;
      word_count_q     <= '0;
      block_count_q    <= '0;
      is_writing_q     <= 1'b0;
      capture_active_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      if (is_writing_q) begin
        word_count_q <= word_count_q + WC_W'(1);
        if (block_done) block_count_q <= block_count_q + BC_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (collect_sync) begin
            state_q          <= DISCARD;
            discard_cnt_q    <= '0;
            word_count_q     <= '0;
            block_count_q    <= '0;
            overflow_q       <= 1'b0;
            capture_active_q <= 1'b1;
          end
        end

        DISCARD: begin
          if (!collect_sync) begin
            state_q          <= IDLE;
            capture_active_q <= 1'b0;
          end else if (discard_cnt_q == DC_LAST) begin
            state_q      <= CAPTURE;
            is_writing_q <= 1'b1;
          end else begin
            discard_cnt_q <= discard_cnt_q + DC_W'(1);
          end
        end

        CAPTURE: begin
          if (bufferOverflow) begin
            state_q          <= ERROR;
            is_writing_q     <= 1'b0;
            capture_active_q <= 1'b0;
            overflow_q       <= 1'b1;
          end else if (!collect_sync) begin
            // Stopping right after a block's last word leaves nothing to drain.
            if (block_done) begin
              state_q          <= IDLE;
              is_writing_q     <= 1'b0;
              capture_active_q <= 1'b0;
            end else begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (bufferOverflow) begin
            state_q          <= ERROR;
            is_writing_q     <= 1'b0;
            capture_active_q <= 1'b0;
            overflow_q       <= 1'b1;
          end else if (block_done) begin
            state_q          <= IDLE;
            is_writing_q     <= 1'b0;
            capture_active_q <= 1'b0;
          end
        end

        ERROR: begin
          if (!collect_sync) state_q <= IDLE;
        end

        default: begin
          state_q          <= IDLE;
          is_writing_q     <= 1'b0;
          capture_active_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAMPLE_WRITER_TEST_PATTERN_EN
  logic              test_mode_q;
  logic [DATA_W-1:0] pattern_q;
  logic [DATA_W-1:0] pattern_d;

  // pattern_q counts words written; pattern_d is the index of the word being loaded.
  always_comb begin
    pattern_d = pattern_q + DATA_W'(is_writing_q);
    if (start) pattern_d = '0;
  end

  // Data path: registered ADC word or test counter
  always_ff @(posedge writeClock or negedge nReset) begin
    if (!nReset) begin
      test_mode_q <= 1'b0;
      pattern_q   <= '0;
      data_out_q  <= '0;
    end else begin
      if (start) test_mode_q <= testMode;
      pattern_q  <= pattern_d;
      data_out_q <= test_mode_q ? pattern_d : adcData;
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = testMode;

  // Data path: registered ADC word
  always_ff @(posedge writeClock or negedge nReset) begin
    if (!nReset) data_out_q <= '0;
    else         data_out_q <= adcData;
  end
`endif

  assign isWriting       = is_writing_q;
  assign dataOut         = data_out_q;
  assign captureActive   = capture_active_q;
  assign overflowLatched = overflow_q;
  assign blockCount      = block_count_q;

endmodule
